// File: rtl/usb_rx_line_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rx_line_fifo: FWFT byte FIFO with live EOL (line) count, optional    |
// | echo path enabled by macro USB_RX_ECHO_EN.                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usb_rx_line_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  EOL_CHAR   = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   lines,
  output logic                  stall,
  input  logic                  stall_clr,
  output logic [7:0]            e_data,
  output logic                  e_valid,
  input  logic                  e_ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] c_one = {{(PW-1){1'b0}}, 1'b1};

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic [PW-1:0] r_lines;
  logic          r_stall;

  logic w_empty;
  logic w_full;
  logic w_echo_free;
  logic w_wr;
  logic w_rd;
  logic w_wr_eol;
  logic w_rd_eol;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

  // rst_n gates s_ready so nothing is accepted while reset is held
  assign s_ready = rst_n & ~w_full & w_echo_free;
  assign m_valid = ~w_empty;
  assign m_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign level   = r_level;
  assign lines   = r_lines;
  assign stall   = r_stall;

  assign w_wr     = s_valid & s_ready;
  assign w_rd     = m_valid & m_ready;
  assign w_wr_eol = w_wr & (s_data == EOL_CHAR);
  assign w_rd_eol = w_rd & (m_data == EOL_CHAR);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_lines  <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_one;

      if (w_wr && !w_rd)      r_level <= r_level + c_one;
      else if (w_rd && !w_wr) r_level <= r_level - c_one;

      if (w_wr_eol && !w_rd_eol)      r_lines <= r_lines + c_one;
      else if (w_rd_eol && !w_wr_eol) r_lines <= r_lines - c_one;

      // a new stall event outranks a simultaneous clear
      if (s_valid && !s_ready) r_stall <= 1'b1;
      else if (stall_clr)      r_stall <= 1'b0;
    end
  end

`ifdef USB_RX_ECHO_EN
  logic       r_echo_valid;
  logic [7:0] r_echo_data;

  // a draining echo slot can take the next byte in the same cycle
  assign w_echo_free = ~r_echo_valid | e_ready;
  assign e_valid     = r_echo_valid;
  assign e_data      = r_echo_valid ? r_echo_data : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_valid <= 1'b0;
      r_echo_data  <= 8'h00;
    end else if (w_wr) begin
      r_echo_valid <= 1'b1;
      r_echo_data  <= s_data;
    end else if (r_echo_valid && e_ready) begin
      r_echo_valid <= 1'b0;
    end
  end
`else
  logic w_unused_e_ready;

  assign w_unused_e_ready = e_ready;
  assign w_echo_free      = 1'b1;
  assign e_valid          = 1'b0;
  assign e_data           = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_line_fifo.sv
`default_nettype none
// Randomized + directed bench for usb_rx_line_fifo against a queue-based model.
module tb_usb_rx_line_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam logic [7:0] EOL = 8'h0D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DL:0]   level;
  logic [DL:0]   lines;
  logic          stall;
  logic          stall_clr;
  logic [7:0]    e_data;
  logic          e_valid;
  logic          e_ready;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_stall;
  bit         m_echo_v;
  logic [7:0] m_echo_d;

  usb_rx_line_fifo #(.DEPTH_LOG2(DL), .EOL_CHAR(EOL)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .lines(lines),
    .stall(stall), .stall_clr(stall_clr),
    .e_data(e_data), .e_valid(e_valid), .e_ready(e_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eol_count();
    int n = 0;
    foreach (q[i]) if (q[i] == EOL) n++;
    return n;
  endfunction

  function automatic bit exp_ready(input bit er);
`ifdef USB_RX_ECHO_EN
    return (q.size() < DEPTH) && (!m_echo_v || er);
`else
    return (q.size() < DEPTH) && (er || !er);
`endif
  endfunction

  // one clock: drive, check outputs against the model, advance model across the edge
  task automatic cycle(input bit sv, input logic [7:0] sd, input bit mr,
                       input bit sc, input bit er);
    bit rdy, wr, rd;
    s_valid = sv; s_data = sd; m_ready = mr; stall_clr = sc; e_ready = er;
    #1;
    rdy = exp_ready(er);
    check_eq("s_ready", 32'(s_ready), 32'(rdy));
    check_eq("m_valid", 32'(m_valid), 32'(q.size() > 0));
    if (q.size() > 0) check_eq("m_data", 32'(m_data), 32'(q[0]));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("lines", 32'(lines), 32'(eol_count()));
    check_eq("stall", 32'(stall), 32'(m_stall));
`ifdef USB_RX_ECHO_EN
    check_eq("e_valid", 32'(e_valid), 32'(m_echo_v));
    if (m_echo_v) check_eq("e_data", 32'(e_data), 32'(m_echo_d));
`else
    check_eq("e_valid", 32'(e_valid), 32'd0);
`endif
    wr = sv && rdy;
    rd = mr && (q.size() > 0);
    if (sv && !rdy)  m_stall = 1'b1;
    else if (sc)     m_stall = 1'b0;
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(sd);
    if (wr) begin
      m_echo_v = 1'b1; m_echo_d = sd;
    end else if (m_echo_v && er) begin
      m_echo_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_stall  = 1'b0;
    m_echo_v = 1'b0;
    m_echo_d = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hAA; m_ready = 1'b0;
    stall_clr = 1'b0; e_ready = 1'b0;
    model_reset();

    // 1: reset with s_valid asserted
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_lines", 32'(lines), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_e_valid", 32'(e_valid), 32'd0);
    check_eq("rst_e_data", 32'(e_data), 32'd0);
    rst_n = 1'b1;
    s_valid = 1'b0;

    // 2: line count
    cycle(1, 8'h41, 0, 0, 1);
    cycle(1, 8'h42, 0, 0, 1);
    cycle(1, EOL,   0, 0, 1);
    cycle(1, 8'h43, 0, 0, 1);
    check_eq("t2_level4", 32'(level), 32'd4);
    check_eq("t2_lines1", 32'(lines), 32'd1);
    cycle(0, 8'h00, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 1);
    check_eq("t2_lines0", 32'(lines), 32'd0);
    check_eq("t2_level1", 32'(level), 32'd1);
    cycle(0, 8'h00, 1, 0, 1);

    // 3: full and wrap
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 1);
    check_eq("t3_full_level", 32'(level), 32'd16);
    check_eq("t3_full_ready", 32'(s_ready), 32'd0);
    cycle(1, 8'hEE, 0, 0, 1);
    check_eq("t3_stall", 32'(stall), 32'd1);
    cycle(1, 8'hEE, 1, 0, 1);     // read while full: still no write
    for (int i = 0; i < 7; i++) cycle(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h10 + i), 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_order", 32'(m_data), 32'(8'h08 + i));
      cycle(0, 8'h00, 1, 1, 1);
    end
    check_eq("t3_empty", 32'(m_valid), 32'd0);

    // 4: simultaneous rd/wr of EOL, and stall vs stall_clr
    cycle(1, EOL, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h61 + i), 0, 0, 1);
    cycle(1, EOL, 1, 0, 1);
    check_eq("t4_level", 32'(level), 32'd5);
    check_eq("t4_lines", 32'(lines), 32'd1);
    for (int i = 0; i < 11; i++) cycle(1, 8'h70, 0, 0, 1);
    cycle(1, 8'h71, 0, 1, 1);
    check_eq("t4_stall_wins", 32'(stall), 32'd1);
    cycle(0, 8'h00, 0, 1, 1);
    check_eq("t4_stall_clr", 32'(stall), 32'd0);
    while (q.size() > 0) cycle(0, 8'h00, 1, 0, 1);

    // 5: empty edge, then reset mid-burst
    cycle(1, 8'h55, 0, 0, 1);
    check_eq("t5_valid_next", 32'(m_valid), 32'd1);
    check_eq("t5_data_next", 32'(m_data), 32'h55);
    cycle(1, 8'h56, 0, 0, 1);
    cycle(1, 8'h57, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(m_valid), 32'd0);
    check_eq("t5_rst_level", 32'(level), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b0;

    // 6: echo backpressure
    cycle(1, 8'h31, 0, 0, 0);
`ifdef USB_RX_ECHO_EN
    check_eq("t6_e_valid", 32'(e_valid), 32'd1);
    check_eq("t6_e_data", 32'(e_data), 32'h31);
    cycle(1, 8'h32, 0, 0, 0);
    check_eq("t6_blocked", 32'(level), 32'd1);
`else
    check_eq("t6_no_echo", 32'(e_valid), 32'd0);
`endif
    cycle(1, 8'h32, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    check_eq("t6_second", 32'(level), 32'd2);
    while (q.size() > 0) cycle(0, 8'h00, 1, 0, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit         sv = ($urandom_range(0, 3) != 0);
      logic [7:0] sd = ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom);
      bit         mr = ($urandom_range(0, 2) == 0);
      bit         sc = ($urandom_range(0, 7) == 0);
      bit         er = ($urandom_range(0, 1) == 0);
      if (n > 1500) mr = ($urandom_range(0, 2) != 0);
      cycle(sv, sd, mr, sc, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
